// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared constants for the PWM block.
//   PWM_BIT_WIDTH : default width of the period counter, duty and terminal count.
package pwm_pkg;

  localparam int PWM_BIT_WIDTH = 8;

endpackage : pwm_pkg

// File: rtl/pwm_if.sv
// pwm_if -- bundles the PWM control inputs and waveform outputs.
//   duty         : requested high-time in clk cycles per period
//   max_value    : terminal count, period = max_value + 1 cycles
//   pwm_out      : registered PWM waveform
//   period_start : one-cycle strobe on the first pwm_out cycle of each period
//                  (present only when PWM_PERIOD_STROBE_EN is defined)
// Modports: master drives the controls (testbench / system side),
//           slave is the PWM generator.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = PWM_BIT_WIDTH
);

  logic [BIT_WIDTH-1:0] duty;
  logic [BIT_WIDTH-1:0] max_value;
  logic                 pwm_out;
`ifdef PWM_PERIOD_STROBE_EN
  logic                 period_start;
`endif

`ifdef PWM_PERIOD_STROBE_EN
  modport master (output duty, output max_value, input pwm_out, input period_start);
  modport slave  (input duty, input max_value, output pwm_out, output period_start);
`else
  modport master (output duty, output max_value, input pwm_out);
  modport slave  (input duty, input max_value, output pwm_out);
`endif

endinterface : pwm_if

// File: rtl/pwm_counter.sv
// pwm_counter -- period counter for pwm_module.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   i_max_act : terminal count of the current period (stable within a period)
//   o_cnt     : position within the period, 0 .. i_max_act
//   o_load_en : high on the last cycle of the period; the edge that ends it
//               wraps the counter and reloads the shadow registers
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = PWM_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] i_max_act,
  output logic [BIT_WIDTH-1:0] o_cnt,
  output logic                 o_load_en
);

  logic [BIT_WIDTH-1:0] r_cnt;
  logic                 w_wrap;

  // Equality against the shadowed terminal count: it cannot change mid-period,
  // so the counter always reaches it and never runs past a wrap.
  assign w_wrap = (r_cnt == i_max_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BIT_WIDTH'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_load_en = w_wrap;

endmodule : pwm_counter

// File: rtl/pwm_module.sv
// pwm_module -- registered PWM generator with period-boundary shadowing.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, forces pwm_out low immediately
//   bus : pwm_if.slave (duty, max_value in; pwm_out, optional period_start out)
// duty and max_value are sampled into shadow registers only when the counter
// wraps, so mid-period changes take effect from the next period.
// Optional feature: define PWM_PERIOD_STROBE_EN to add the period_start strobe.
module pwm_module
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH = PWM_BIT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);

  logic [BIT_WIDTH-1:0] r_duty_act;
  logic [BIT_WIDTH-1:0] r_max_act;
  logic                 r_pwm_out;
  logic [BIT_WIDTH-1:0] w_cnt;
  logic                 w_load_en;

  pwm_counter #(.BIT_WIDTH(BIT_WIDTH)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_max_act (r_max_act),
    .o_cnt     (w_cnt),
    .o_load_en (w_load_en)
  );

  // duty_act > max_act gives constant high, duty_act == 0 constant low,
  // both fall out of the plain unsigned compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_act <= '0;
      r_max_act  <= '0;
      r_pwm_out  <= 1'b0;
    end else begin
      if (w_load_en) begin
        r_duty_act <= bus.duty;
        r_max_act  <= bus.max_value;
      end
      r_pwm_out <= (w_cnt < r_duty_act);
    end
  end

  assign bus.pwm_out = r_pwm_out;

`ifdef PWM_PERIOD_STROBE_EN
  // Registered alongside pwm_out, so it lines up with the first output cycle
  // of each period (every cycle when max_act == 0).
  logic r_period_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= (w_cnt == '0);
    end
  end

  assign bus.period_start = r_period_start;
`endif

endmodule : pwm_module

// File: tb/tb_pwm_module.sv
// tb_pwm_module -- self-checking bench for pwm_module (BIT_WIDTH = 3).
// The reference builds whole periods as bit lists from the duty/max values
// present at each period boundary and compares pwm_out cycle by cycle.
module tb_pwm_module;

  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst;

  pwm_if #(.BIT_WIDTH(BW)) u_if ();

  pwm_module #(.BIT_WIDTH(BW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit exp_q[$];
  bit st_q[$];
  bit exp_pwm;
  bit exp_ps;
  int d_in;
  int m_in;
  int hi_cnt;
  int ps_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input int d, input int m);
    d_in = d;
    m_in = m;
    u_if.duty      = BW'(d);
    u_if.max_value = BW'(m);
  endtask

  // One period of m+1 cycles: the first d are high (all high when d > m).
  task automatic gen_period(input int d, input int m);
    for (int i = 0; i <= m; i++) begin
      exp_q.push_back(i < d);
      st_q.push_back(i == 0);
    end
  endtask

  // Out of reset the generator runs a 1-cycle period with zero duty.
  task automatic model_reset();
    exp_q.delete();
    st_q.delete();
    gen_period(0, 0);
  endtask

  task automatic model_step();
    exp_pwm = exp_q.pop_front();
    exp_ps  = st_q.pop_front();
    if (exp_q.size() == 0) gen_period(d_in, m_in);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("pwm", int'(u_if.pwm_out), int'(exp_pwm));
    hi_cnt += int'(u_if.pwm_out);
`ifdef PWM_PERIOD_STROBE_EN
    chk("pstart", int'(u_if.period_start), int'(exp_ps));
    ps_cnt += int'(u_if.period_start);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    set_in(0, 0);
    model_reset();
    #2;
    chk("rst_pwm", int'(u_if.pwm_out), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", int'(u_if.pwm_out), 0);
`ifdef PWM_PERIOD_STROBE_EN
    chk("rst_ps", int'(u_if.period_start), 0);
`endif
    rst = 1'b0;
    model_reset();

    // 3 high / 5 low, period 8
    set_in(3, 7);
    run(20);
    hi_cnt = 0;
    run(8);
    chk("pat3of8", hi_cnt, 3);

    // duty sweep with max 7
    for (int d = 0; d < 8; d++) begin
      set_in(d, 7);
      run(16);
      hi_cnt = 0;
      run(8);
      chk("sweep_hi", hi_cnt, d);
    end

    // duty beyond the terminal count, and the 1-cycle period
    set_in(6, 4);
    run(12);
    hi_cnt = 0;
    run(10);
    chk("full_m4", hi_cnt, 10);
    set_in(1, 0);
    run(12);
    hi_cnt = 0;
    run(10);
    chk("full_m0", hi_cnt, 10);

    // mid-period duty change 2 -> 5
    set_in(2, 7);
    run(16);
    k = 0;
    while (exp_q.size() != 6 && k < 16) begin
      cycle();
      k++;
    end
    chk("mid_sync", exp_q.size(), 6);
    set_in(5, 7);
    hi_cnt = 0;
    run(14);
    chk("mid_chg", hi_cnt, 5);

    // reset pulse between edges while the output is high
    set_in(4, 7);
    run(16);
    k = 0;
    while (!(exp_pwm == 1'b1 && exp_q.size() > 2) && k < 16) begin
      cycle();
      k++;
    end
    chk("rst_sync", int'(exp_pwm), 1);
    chk("pre_rst_hi", int'(u_if.pwm_out), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", int'(u_if.pwm_out), 0);
`ifdef PWM_PERIOD_STROBE_EN
    chk("rst_async_ps", int'(u_if.period_start), 0);
`endif
    #1;
    rst = 1'b0;
    model_reset();
    run(1);
    hi_cnt = 0;
    run(8);
    chk("post_rst", hi_cnt, 4);

`ifdef PWM_PERIOD_STROBE_EN
    set_in(2, 3);
    run(12);
    ps_cnt = 0;
    run(16);
    chk("pstart_cnt", ps_cnt, 4);
`endif

    // randomized control changes, including mid-period ones
    repeat (300) begin
      if ($urandom_range(0, 4) == 0)
        set_in(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pwm_module

// File: doc/pwm_module.md
PWM_MODULE -- requirements
Module: pwm_module

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: width of the counter, duty and max_value (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high (one clock; reset asynchronous, active-high).
REQ-004 SHALL have port duty, input, BIT_WIDTH bits: requested high-time in clk cycles per period, unsigned.
REQ-005 SHALL have port max_value, input, BIT_WIDTH bits: terminal count; the period is max_value+1 cycles, unsigned.
REQ-006 SHALL have port pwm_out, output, 1 bit: registered PWM waveform.

Function
REQ-007 SHALL hold a BIT_WIDTH-bit period counter cnt that increments by 1 each cycle and wraps to 0 on the cycle after cnt == max_act.
REQ-008 SHALL hold shadow registers duty_act and max_act, loaded from duty and max_value only on the edge where cnt wraps (cnt == max_act); mid-period input changes SHALL NOT affect the current period.
REQ-009 SHALL register pwm_out <= (cnt < duty_act) each rising edge, giving exactly one cycle of latency from cnt to pwm_out.
REQ-010 SHALL produce exactly duty_act high cycles followed by max_act+1-duty_act low cycles per period when duty_act <= max_act.
REQ-011 SHALL drive pwm_out constantly high when duty_act > max_act (100% duty).
REQ-012 SHALL drive pwm_out constantly low when duty_act == 0.
REQ-013 SHALL treat max_act == 0 as a 1-cycle period: cnt stays 0, and shadows reload every cycle.
REQ-014 SHALL handle a max_value decrease below the current cnt by reloading only at the wrap; cnt SHALL never skip the wrap check (the compare is equality against max_act, which is stable within a period).
REQ-015 SHALL perform all compares unsigned at BIT_WIDTH bits, with no widening of duty.

Reset
REQ-016 SHALL, while rst is high, force cnt=0, duty_act=0, max_act=0, pwm_out=0 asynchronously.
REQ-017 SHALL, on the first edge after rst deasserts, load the shadows from the inputs (since cnt == max_act == 0) and begin a new period.
REQ-018 SHALL, when rst asserts mid-period, abort the period immediately with pwm_out low, without waiting for a clock edge.

Configuration
REQ-019 SHALL, with macro PWM_PERIOD_STROBE_EN defined, add output period_start (1 bit), registered, high for exactly one cycle aligned with the first pwm_out cycle of each period, reset value 0.
REQ-020 SHALL, without PWM_PERIOD_STROBE_EN, have no period_start port and no related logic.

Structure
REQ-021 SHALL take the default BIT_WIDTH constant from shared package pwm_pkg; the package SHALL NOT hold other typedefs.
REQ-022 SHALL implement cnt, the wrap detect and the shadow-load enable in one sub-module, pwm_counter; the compare and output register live in pwm_module.

Verification
REQ-023 SHALL cover: BIT_WIDTH=3, max_value=7, duty=3 -> repeating pattern of 3 high, 5 low, period 8.
REQ-024 SHALL cover: BIT_WIDTH=3, max_value=7, duty 0..7 swept at period boundaries -> high count per period equals duty; duty=0 gives constant 0.
REQ-025 SHALL cover: max_value=4, duty=6 -> pwm_out constant 1; max_value=0, duty=1 -> constant 1.
REQ-026 SHALL cover: duty changed 2->5 mid-period with max_value=7 -> the current period keeps 2 high cycles and the next period has 5.
REQ-027 SHALL cover: rst pulsed between clock edges mid-high -> pwm_out 0 immediately; after release the first full period matches the duty.
REQ-028 SHALL cover: with PWM_PERIOD_STROBE_EN, max_value=3 -> period_start high 1 cycle in every 4, coincident with the first pwm_out cycle of the period.
